// File: rtl/multi_wave_gen_pkg.sv
// Shared types and the waveform shaping helper for the multi-channel tone generator.
// The optional mix output is selected with the MULTI_WAVE_GEN_MIX_EN macro in multi_wave_gen.sv.
package multi_wave_gen_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SILENT = 2'd3
    } wave_mode_t;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        DIVIDE = 2'd1,
        WRITE  = 2'd2
    } div_state_t;

    // Widest sample the shaping helper can produce.
    localparam int SHAPE_MAX_W = 32;

    // Maps the top w bits of a phase (right-aligned in p) to a w-bit two's-complement
    // sample, returned in the low w bits. w is a constant at every call site.
    function automatic logic [SHAPE_MAX_W-1:0] wave_shape(
        input logic [SHAPE_MAX_W-1:0] p,
        input wave_mode_t             mode,
        input int                     w
    );
        logic [SHAPE_MAX_W-1:0] mask;
        logic [SHAPE_MAX_W-1:0] top;
        logic [SHAPE_MAX_W-1:0] mag;
        logic [SHAPE_MAX_W-1:0] u;
        logic [SHAPE_MAX_W-1:0] res;
        // A shift by the full word width yields zero, so w == 32 still gives an all-ones mask.
        mask = (32'd1 << w) - 32'd1;
        top  = 32'd1 << (w - 1);
        mag  = top - 32'd1;
        u    = 32'd0;
        res  = 32'd0;
        case (mode)
            WAVE_SAW: begin
                res = p & mask;
            end
            WAVE_SQUARE: begin
                if ((p & top) != 32'd0) begin
                    res = (~mag + 32'd1) & mask;
                end else begin
                    res = mag;
                end
            end
            WAVE_TRI: begin
                u = (p << 1) & mask;
                if ((p & top) != 32'd0) begin
                    u = ~u & mask;
                end else begin
                    u = u;
                end
                res = u ^ top;
            end
            WAVE_SILENT: begin
                res = 32'd0;
            end
            default: begin
                res = 32'd0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multi_wave_gen_div.sv
// Shared restoring divider: inc = floor(rate * 2^PHASE_WIDTH / SAMPLE_RATE).
// One quotient bit per cycle, MSB first; zero and out-of-range rates finish at start.
import multi_wave_gen_pkg::*;

module rate_to_inc_div #(
    parameter int PHASE_WIDTH = 24,
    parameter int RATE_WIDTH  = 11,
    parameter int SAMPLE_RATE = 48000
) (
    input  logic                   clk_audio,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [RATE_WIDTH-1:0]  rate,
    output logic                   busy,
    output logic                   done,
    output logic [PHASE_WIDTH-1:0] inc,
    output logic                   err
);

    // Remainder stays below SAMPLE_RATE, so twice it needs one extra bit.
    localparam int REM_W = $clog2(SAMPLE_RATE) + 1;
    localparam int CNT_W = $clog2(PHASE_WIDTH + 1);
    localparam logic [REM_W-1:0] SR_REM  = REM_W'(SAMPLE_RATE);
    localparam logic [CNT_W-1:0] PW_CNT  = CNT_W'(PHASE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    logic [REM_W-1:0]       rem_r;
    logic [REM_W-1:0]       rem_shift_s;
    logic [REM_W-1:0]       rem_next_s;
    logic [PHASE_WIDTH-1:0] quo_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   err_r;
    logic                   done_r;
    logic                   bit_s;
    logic                   rate_bad_s;
    logic                   rate_zero_s;

    // Classify the incoming request and compute one restoring-division step.
    always_comb begin
        rate_bad_s  = (32'(rate) >= 32'(SAMPLE_RATE));
        rate_zero_s = (rate == {RATE_WIDTH{1'b0}});
        rem_shift_s = {rem_r[REM_W-2:0], 1'b0};
        if (rem_shift_s >= SR_REM) begin
            bit_s      = 1'b1;
            rem_next_s = rem_shift_s - SR_REM;
        end else begin
            bit_s      = 1'b0;
            rem_next_s = rem_shift_s;
        end
    end

    // Load on start, then shift in one quotient bit per cycle until the count runs out.
    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            rem_r  <= {REM_W{1'b0}};
            quo_r  <= {PHASE_WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            err_r <= rate_bad_s;
            quo_r <= {PHASE_WIDTH{1'b0}};
            if (rate_bad_s || rate_zero_s) begin
                rem_r  <= {REM_W{1'b0}};
                cnt_r  <= {CNT_W{1'b0}};
                done_r <= 1'b0;
            end else begin
                rem_r  <= REM_W'(rate);
                cnt_r  <= PW_CNT;
                done_r <= (PW_CNT == CNT_ONE);
            end
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            rem_r  <= rem_next_s;
            quo_r  <= {quo_r[PHASE_WIDTH-2:0], bit_s};
            cnt_r  <= cnt_r - CNT_ONE;
            // done marks the cycle performing the final step.
            done_r <= (cnt_r == CNT_TWO);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy = (cnt_r != {CNT_W{1'b0}});
    assign done = done_r;
    assign inc  = quo_r;
    assign err  = err_r;

endmodule

// File: rtl/multi_wave_gen.sv
// Multi-channel saw/square/triangle tone generator with per-channel phase accumulators.
// Increments are recomputed from Hz requests by one shared divider scanned round-robin.
// Optional: define MULTI_WAVE_GEN_MIX_EN to add a saturated sum-of-channels output "mix".
import multi_wave_gen_pkg::*;

module multi_wave_gen #(
    parameter int BIT_WIDTH    = 16,
    parameter int SAMPLE_RATE  = 48000,
    parameter int PHASE_WIDTH  = 24,
    parameter int RATE_WIDTH   = 11,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                              clk_audio,
    input  logic                              reset_n,
    input  logic                              sample_en,
    input  logic [NUM_CHANNELS*RATE_WIDTH-1:0] wave_rate,
    input  logic [NUM_CHANNELS*2-1:0]          mode,
    input  logic [NUM_CHANNELS-1:0]            enable,
    output logic [NUM_CHANNELS*BIT_WIDTH-1:0]  level,
    output logic                              sample_valid,
    output logic [NUM_CHANNELS-1:0]            rate_err
`ifdef MULTI_WAVE_GEN_MIX_EN
    ,
    output logic signed [BIT_WIDTH-1:0]       mix
`endif
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Divider control state.
    div_state_t              state_r;
    div_state_t              state_next_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_next_s;
    logic [IDX_W-1:0]        idx_inc_s;
    logic [RATE_WIDTH-1:0]   cur_rate_s;
    logic                    fast_s;
    logic                    div_start_s;
    logic                    latch_s;
    logic                    write_s;
    logic                    div_busy_s;
    logic                    div_done_s;
    logic [PHASE_WIDTH-1:0]  div_inc_s;
    logic                    div_err_s;

    // Per-channel state.
    logic [RATE_WIDTH-1:0]   latched_r    [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0]  inc_r        [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0]  phase_r      [NUM_CHANNELS];
    logic [PHASE_WIDTH-1:0]  phase_next_s [NUM_CHANNELS];
    logic signed [BIT_WIDTH-1:0] level_r      [NUM_CHANNELS];
    logic signed [BIT_WIDTH-1:0] level_next_s [NUM_CHANNELS];
    logic [SHAPE_MAX_W-1:0]  shape_s      [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] rate_err_r;
    logic                    sample_valid_r;

    rate_to_inc_div #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .RATE_WIDTH  (RATE_WIDTH),
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_div (
        .clk_audio (clk_audio),
        .reset_n   (reset_n),
        .start     (div_start_s),
        .rate      (cur_rate_s),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .inc       (div_inc_s),
        .err       (div_err_s)
    );

    // Select the scanned channel's request and decide whether it can skip the divide.
    always_comb begin
        cur_rate_s = wave_rate[int'(idx_r)*RATE_WIDTH +: RATE_WIDTH];
        fast_s     = (cur_rate_s == {RATE_WIDTH{1'b0}}) ||
                     (32'(cur_rate_s) >= 32'(SAMPLE_RATE));
        if (idx_r == IDX_LAST) begin
            idx_inc_s = {IDX_W{1'b0}};
        end else begin
            idx_inc_s = idx_r + IDX_ONE;
        end
    end

    // Next-state logic for the scan / divide / write sequence.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        div_start_s  = 1'b0;
        latch_s      = 1'b0;
        write_s      = 1'b0;
        case (state_r)
            SCAN: begin
                if (cur_rate_s != latched_r[idx_r]) begin
                    latch_s     = 1'b1;
                    div_start_s = 1'b1;
                    if (fast_s) begin
                        state_next_s = WRITE;
                    end else begin
                        state_next_s = DIVIDE;
                    end
                end else begin
                    idx_next_s = idx_inc_s;
                end
            end
            DIVIDE: begin
                if (div_done_s) begin
                    state_next_s = WRITE;
                end else if (div_busy_s) begin
                    state_next_s = DIVIDE;
                end else begin
                    // Divider idle without finishing: rescan rather than stall.
                    state_next_s = SCAN;
                end
            end
            WRITE: begin
                write_s      = 1'b1;
                idx_next_s   = idx_inc_s;
                state_next_s = SCAN;
            end
            default: begin
                state_next_s = SCAN;
                idx_next_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Divider control state register.
    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= SCAN;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Latch requested rates and commit finished increments and error flags.
    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                latched_r[c] <= {RATE_WIDTH{1'b0}};
                inc_r[c]     <= {PHASE_WIDTH{1'b0}};
            end
            rate_err_r <= {NUM_CHANNELS{1'b0}};
        end else begin
            if (latch_s) begin
                latched_r[idx_r] <= cur_rate_s;
            end
            if (write_s) begin
                inc_r[idx_r]      <= div_inc_s;
                rate_err_r[idx_r] <= div_err_s;
            end
        end
    end

    // Shape each channel from its pre-update phase and compute next phase/level.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            shape_s[c]      = wave_shape(32'(phase_r[c][PHASE_WIDTH-1 -: BIT_WIDTH]),
                                         wave_mode_t'(mode[c*2 +: 2]), BIT_WIDTH);
            level_next_s[c] = level_r[c];
            phase_next_s[c] = phase_r[c];
            if (!enable[c]) begin
                level_next_s[c] = {BIT_WIDTH{1'b0}};
                phase_next_s[c] = {PHASE_WIDTH{1'b0}};
            end else if (sample_en) begin
                level_next_s[c] = shape_s[c][BIT_WIDTH-1:0];
                phase_next_s[c] = phase_r[c] + inc_r[c];
            end else begin
                level_next_s[c] = level_r[c];
                phase_next_s[c] = phase_r[c];
            end
        end
    end

    // Phase accumulators, sample registers and the valid strobe.
    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                phase_r[c] <= {PHASE_WIDTH{1'b0}};
                level_r[c] <= {BIT_WIDTH{1'b0}};
            end
            sample_valid_r <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                phase_r[c] <= phase_next_s[c];
                level_r[c] <= level_next_s[c];
            end
            sample_valid_r <= sample_en;
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pack
        assign level[c*BIT_WIDTH +: BIT_WIDTH] = level_r[c];
    end

    assign sample_valid = sample_valid_r;
    assign rate_err     = rate_err_r;

`ifdef MULTI_WAVE_GEN_MIX_EN
    localparam int MIX_W = BIT_WIDTH + $clog2(NUM_CHANNELS);
    localparam logic signed [MIX_W-1:0] MIX_MAX = MIX_W'((2 ** (BIT_WIDTH - 1)) - 1);
    localparam logic signed [MIX_W-1:0] MIX_MIN = MIX_W'(-(2 ** (BIT_WIDTH - 1)));

    logic signed [MIX_W-1:0]     sum_s;
    logic signed [BIT_WIDTH-1:0] mix_next_s;
    logic signed [BIT_WIDTH-1:0] mix_r;

    // Sum the levels being registered this edge and clamp to the sample range.
    always_comb begin
        sum_s = {MIX_W{1'b0}};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sum_s = sum_s + MIX_W'(level_next_s[c]);
        end
        if (sum_s > MIX_MAX) begin
            mix_next_s = MIX_MAX[BIT_WIDTH-1:0];
        end else if (sum_s < MIX_MIN) begin
            mix_next_s = MIX_MIN[BIT_WIDTH-1:0];
        end else begin
            mix_next_s = sum_s[BIT_WIDTH-1:0];
        end
    end

    // Mix register, updated alongside the channel levels.
    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            mix_r <= {BIT_WIDTH{1'b0}};
        end else begin
            mix_r <= mix_next_s;
        end
    end

    assign mix = mix_r;
`endif

endmodule

// File: tb/tb_multi_wave_gen.sv
// Self-checking bench for multi_wave_gen: constant waveform table, scoreboard against
// an independent phase/waveform model, and hand-written rate-error / reset sequences.
module tb_multi_wave_gen;

    localparam int NC = 2;
    localparam int BW = 16;
    localparam int PW = 24;
    localparam int RW = 16;
    localparam int SR = 48000;

    logic              clk_audio = 1'b0;
    logic              reset_n;
    logic              sample_en;
    logic [NC*RW-1:0]  wave_rate;
    logic [NC*2-1:0]   mode;
    logic [NC-1:0]     enable;
    logic [NC*BW-1:0]  level;
    logic              sample_valid;
    logic [NC-1:0]     rate_err;
`ifdef MULTI_WAVE_GEN_MIX_EN
    logic [BW-1:0]     mix;
`endif

    always #5 clk_audio = ~clk_audio;

    multi_wave_gen #(
        .BIT_WIDTH(BW), .SAMPLE_RATE(SR), .PHASE_WIDTH(PW),
        .RATE_WIDTH(RW), .NUM_CHANNELS(NC)
    ) dut (
        .clk_audio    (clk_audio),
        .reset_n      (reset_n),
        .sample_en    (sample_en),
        .wave_rate    (wave_rate),
        .mode         (mode),
        .enable       (enable),
        .level        (level),
        .sample_valid (sample_valid),
        .rate_err     (rate_err)
`ifdef MULTI_WAVE_GEN_MIX_EN
        ,
        .mix          (mix)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [NC*BW-1:0] lev;
        logic [BW-1:0]    mix;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    typedef struct {
        logic [1:0] md;
        int         idx;
        int         exp;
        string      name;
    } vec_t;
    vec_t tbl[18];

    logic [PW-1:0] m_phase [NC];
    logic [PW-1:0] m_inc   [NC];

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [PW-1:0] calc_inc(input int r);
        longint q;
        if (r <= 0 || r >= SR) return {PW{1'b0}};
        q = (longint'(r) << PW) / longint'(SR);
        return q[PW-1:0];
    endfunction

    function automatic int model_wave(input logic [BW-1:0] p, input logic [1:0] md);
        int half;
        half = 2 ** (BW - 1);
        case (md)
            2'd0: return int'($signed(p));
            2'd1: return p[BW-1] ? -(half - 1) : (half - 1);
            2'd2: begin
                if (!p[BW-1]) return -half + 2 * int'(p);
                else          return (half - 1) - 2 * (int'(p) - half);
            end
            default: return 0;
        endcase
    endfunction

    // Scoreboard consumer: one expected record per sample_valid strobe.
    always @(negedge clk_audio) begin
        if (reset_n === 1'b1 && sample_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: got an unexpected sample_valid, expected none");
            end else begin
                mon_e = sb_q.pop_front();
                for (int c = 0; c < NC; c++) begin
                    check($sformatf("sb_level_ch%0d", c), int'($signed(level[c*BW +: BW])),
                          int'($signed(mon_e.lev[c*BW +: BW])));
                end
`ifdef MULTI_WAVE_GEN_MIX_EN
                check("sb_mix", int'($signed(mix)), int'($signed(mon_e.mix)));
`endif
            end
        end
    end

    task automatic drive_rate(input int c, input int r);
        @(negedge clk_audio);
        wave_rate[c*RW +: RW] = RW'(r);
        m_inc[c] = calc_inc(r);
    endtask

    task automatic set_rate(input int c, input int r);
        drive_rate(c, r);
        repeat (NC + PW + 4) @(negedge clk_audio);
    endtask

    task automatic do_sample(output int lev0, output int lev1);
        sb_t e;
        int  v;
        int  sum;
        int  half;
        half = 2 ** (BW - 1);
        @(negedge clk_audio);
        sum = 0;
        e   = '0;
        for (int c = 0; c < NC; c++) begin
            if (enable[c]) begin
                v = model_wave(m_phase[c][PW-1 -: BW], mode[c*2 +: 2]);
                m_phase[c] = m_phase[c] + m_inc[c];
            end else begin
                v = 0;
                m_phase[c] = {PW{1'b0}};
            end
            e.lev[c*BW +: BW] = BW'(v);
            sum += v;
        end
        if (sum > half - 1) sum = half - 1;
        if (sum < -half)    sum = -half;
        e.mix = BW'(sum);
        sb_q.push_back(e);
        sample_en = 1'b1;
        @(negedge clk_audio);
        sample_en = 1'b0;
        lev0 = int'($signed(level[0 +: BW]));
        lev1 = int'($signed(level[BW +: BW]));
        repeat (2) @(negedge clk_audio);
        check("valid_low_between", int'(sample_valid), 0);
    endtask

    task automatic restart(input int c);
        @(negedge clk_audio);
        enable[c]  = 1'b0;
        m_phase[c] = {PW{1'b0}};
        @(negedge clk_audio);
        check($sformatf("en_drop_ch%0d", c), int'($signed(level[c*BW +: BW])), 0);
        enable[c] = 1'b1;
    endtask

    task automatic wait_err(input int c, input logic exp, input string name);
        int k;
        k = 0;
        while (rate_err[c] !== exp && k < NC + PW + 2) begin
            @(negedge clk_audio);
            k++;
        end
        check(name, int'(rate_err[c]), int'(exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation still running, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int l0, l1, la, lb;

        tbl[0]  = '{2'd0, 0,  0,      "saw_s0"};
        tbl[1]  = '{2'd0, 1,  1024,   "saw_s1"};
        tbl[2]  = '{2'd0, 2,  2048,   "saw_s2"};
        tbl[3]  = '{2'd0, 31, 31744,  "saw_s31"};
        tbl[4]  = '{2'd0, 32, -32768, "saw_s32_wrap"};
        tbl[5]  = '{2'd0, 63, -1024,  "saw_s63"};
        tbl[6]  = '{2'd0, 64, 0,      "saw_s64_period"};
        tbl[7]  = '{2'd1, 0,  32767,  "sq_s0"};
        tbl[8]  = '{2'd1, 31, 32767,  "sq_s31"};
        tbl[9]  = '{2'd1, 32, -32767, "sq_s32"};
        tbl[10] = '{2'd1, 63, -32767, "sq_s63"};
        tbl[11] = '{2'd1, 64, 32767,  "sq_s64"};
        tbl[12] = '{2'd2, 0,  -32768, "tri_s0"};
        tbl[13] = '{2'd2, 8,  -16384, "tri_s8"};
        tbl[14] = '{2'd2, 16, 0,      "tri_s16"};
        tbl[15] = '{2'd2, 32, 32767,  "tri_s32"};
        tbl[16] = '{2'd2, 48, -1,     "tri_s48"};
        tbl[17] = '{2'd3, 5,  0,      "silent_s5"};

        reset_n   = 1'b0;
        sample_en = 1'b0;
        wave_rate = '0;
        mode      = '0;
        enable    = '0;
        for (int c = 0; c < NC; c++) begin
            m_phase[c] = '0;
            m_inc[c]   = '0;
        end
        repeat (3) @(negedge clk_audio);
        check("rst_level_ch0", int'($signed(level[0 +: BW])), 0);
        check("rst_level_ch1", int'($signed(level[BW +: BW])), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_rate_err", int'(rate_err), 0);
        reset_n = 1'b1;

        enable = '1;
        set_rate(0, 750);

        // Table-driven waveform shapes on channel 0 at 750 Hz.
        for (int t = 0; t < 18; t++) begin
            mode[1:0] = tbl[t].md;
            restart(0);
            for (int s = 0; s <= tbl[t].idx; s++) begin
                do_sample(l0, l1);
            end
            check(tbl[t].name, l0, tbl[t].exp);
        end

        // Phase-continuous frequency change 750 -> 1500 after sample 9.
        mode[1:0] = 2'd0;
        restart(0);
        for (int s = 0; s < 10; s++) do_sample(l0, l1);
        set_rate(0, 1500);
        do_sample(la, l1);
        do_sample(lb, l1);
        check("midtone_s10", la, 10240);
        check("midtone_step", lb - la, 2048);

        // Out-of-range request on channel 1 and its recovery.
        drive_rate(1, 48000);
        wait_err(1, 1'b1, "err_set_48000");
        repeat (NC + PW + 4) @(negedge clk_audio);
        restart(1);
        for (int s = 0; s < 3; s++) begin
            do_sample(l0, l1);
            check("err_ch1_level_zero", l1, 0);
        end
        drive_rate(1, 750);
        wait_err(1, 1'b0, "err_clear_750");
        repeat (NC + PW + 4) @(negedge clk_audio);
        for (int s = 0; s < 3; s++) do_sample(l0, l1);
        set_rate(1, 47999);
        check("err_47999", int'(rate_err[1]), 0);
        for (int s = 0; s < 3; s++) do_sample(l0, l1);
        drive_rate(1, 65535);
        wait_err(1, 1'b1, "err_set_65535");
        repeat (NC + PW + 4) @(negedge clk_audio);

        // Asynchronous reset while channel 0 is mid-divide.
        drive_rate(0, 3000);
        repeat (6) @(negedge clk_audio);
        reset_n = 1'b0;
        #1;
        check("arst_level_ch0", int'($signed(level[0 +: BW])), 0);
        check("arst_level_ch1", int'($signed(level[BW +: BW])), 0);
        check("arst_valid", int'(sample_valid), 0);
        check("arst_rate_err", int'(rate_err), 0);
        for (int c = 0; c < NC; c++) m_phase[c] = '0;
        wave_rate[RW +: RW] = RW'(750);
        m_inc[1] = calc_inc(750);
        repeat (2) @(negedge clk_audio);
        reset_n = 1'b1;
        repeat (2 * (PW + 2) + NC + 6) @(negedge clk_audio);
        check("post_rst_err", int'(rate_err), 0);
        do_sample(l0, l1);
        check("post_rst_s0", l0, 0);
        do_sample(l0, l1);
        check("post_rst_s1_ch0", l0, 4096);
        check("post_rst_s1_ch1", l1, 1024);
        for (int s = 0; s < 4; s++) do_sample(l0, l1);

`ifdef MULTI_WAVE_GEN_MIX_EN
        // Two identical saw channels: mix saturates once the sum passes full scale.
        mode = '0;
        drive_rate(1, 750);
        set_rate(0, 750);
        restart(0);
        restart(1);
        for (int s = 0; s < 32; s++) do_sample(l0, l1);
        check("mix_s31_sat", int'($signed(mix)), 32767);
`endif

        repeat (4) @(negedge clk_audio);
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
